// File: rtl/uop_queue.sv
// Circular micro-op queue between decode and rename: up to WIDTH uops in/out per cycle, full flush.
// Optional UOP_QUEUE_STATS_EN adds saturating stall/empty cycle counters.

package uop_pkg;
  localparam int unsigned INSTR_Q_DEPTH = 32;
  localparam int unsigned INSTR_Q_WIDTH = 4;

  typedef enum logic [5:0] {
    UOP_NOP = 6'd0,
    UOP_ADD = 6'd1,
    UOP_SUB = 6'd2,
    UOP_AND = 6'd3,
    UOP_ORR = 6'd4,
    UOP_LDR = 6'd5,
    UOP_STR = 6'd6,
    UOP_BR  = 6'd7
  } uop_op_e;

  typedef struct packed {
    uop_op_e     uopcode;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
    logic [31:0] pc;
  } uop_insn;
endpackage

module uop_queue #(
  parameter  int unsigned DEPTH = uop_pkg::INSTR_Q_DEPTH,
  parameter  int unsigned WIDTH = uop_pkg::INSTR_Q_WIDTH,
  localparam int unsigned CNT_W = $clog2(DEPTH + 1),
  localparam int unsigned DQ_W  = $clog2(WIDTH + 1)
) (
  input  logic                             clk_in,
  input  logic                             rst_N_in,
  input  logic                             flush_in,
  input  logic [WIDTH-1:0]                 enq_valid_in,
  input  uop_pkg::uop_insn [WIDTH-1:0]     enq_uop_in,
  output logic                             enq_ready_out,
  output logic [WIDTH-1:0]                 deq_valid_out,
  output uop_pkg::uop_insn [WIDTH-1:0]     deq_uop_out,
  input  logic [DQ_W-1:0]                  deq_count_in,
  output logic [CNT_W-1:0]                 count_out
`ifdef UOP_QUEUE_STATS_EN
  ,
  output logic [31:0]                      stall_cycles_out,
  output logic [31:0]                      empty_cycles_out
`endif
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  uop_pkg::uop_insn   mem [DEPTH];
  logic [PTR_W-1:0]   head_q;
  logic [PTR_W-1:0]   tail_q;
  logic [DQ_W-1:0]    n_enq;
  logic [CNT_W-1:0]   n_deq;
  logic [CNT_W-1:0]   deq_req;
  logic [CNT_W-1:0]   count_next;
  logic               ready_next;
  logic               run;

  // Leading contiguous run of valid lanes; nothing is accepted while not ready.
  always_comb begin
    n_enq = '0;
    run   = 1'b1;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      run = run & enq_valid_in[i];
      if (run) n_enq = n_enq + DQ_W'(1);
    end
    if (!enq_ready_out) n_enq = '0;
  end

  // Dequeue request clamped to current occupancy.
  always_comb begin
    deq_req    = CNT_W'(deq_count_in);
    n_deq      = (deq_req > count_out) ? count_out : deq_req;
    count_next = count_out + CNT_W'(n_enq) - n_deq;
    ready_next = (count_next <= CNT_W'(DEPTH - WIDTH));
  end

  always_ff @(posedge clk_in or negedge rst_N_in) begin
    if (!rst_N_in) begin
      head_q        <= '0;
      tail_q        <= '0;
      count_out     <= '0;
      enq_ready_out <= 1'b1;
    end else if (flush_in) begin
      head_q        <= '0;
      tail_q        <= '0;
      count_out     <= '0;
      enq_ready_out <= 1'b1;
    end else begin
      head_q        <= head_q + PTR_W'(n_deq);
      tail_q        <= tail_q + PTR_W'(n_enq);
      count_out     <= count_next;
      enq_ready_out <= ready_next;
    end
  end

  // Storage needs no reset: entries beyond count are masked on the read side.
  always_ff @(posedge clk_in) begin
    if (!flush_in) begin
      for (int unsigned i = 0; i < WIDTH; i++) begin
        if (DQ_W'(i) < n_enq) mem[tail_q + PTR_W'(i)] <= enq_uop_in[i];
      end
    end
  end

  // Show-ahead head window.
  always_comb begin
    deq_valid_out = '0;
    deq_uop_out   = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (count_out > CNT_W'(i)) begin
        deq_valid_out[i] = 1'b1;
        deq_uop_out[i]   = mem[head_q + PTR_W'(i)];
      end
    end
  end

`ifdef UOP_QUEUE_STATS_EN
  always_ff @(posedge clk_in or negedge rst_N_in) begin
    if (!rst_N_in) begin
      stall_cycles_out <= '0;
      empty_cycles_out <= '0;
    end else begin
      if ((|enq_valid_in) && !enq_ready_out && (stall_cycles_out != 32'hFFFF_FFFF))
        stall_cycles_out <= stall_cycles_out + 32'd1;
      if ((count_out == '0) && (empty_cycles_out != 32'hFFFF_FFFF))
        empty_cycles_out <= empty_cycles_out + 32'd1;
    end
  end
`endif

endmodule
